serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_tx_if.sv | 17 +
 rtl/serial_frame_tx.sv | 117 +++++++++++
 tb/tb_serial_frame_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
// Parallel frame handshake between a frame source and serial_frame_tx.
//   valid : source offers a frame this cycle
//   ready : transmitter can accept a frame this cycle
//   cmd   : 8-bit command field
//   addr  : 24-bit address field
//   data  : 32-bit data field
// The master modport is the frame source. The slave modport is the transmitter.
interface serial_frame_tx_if;
  logic        valid;
  logic        ready;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic [31:0] data;

  modport master (output valid, output cmd, output addr, output data, input ready);
  modport slave  (input valid, input cmd, input addr, input data, output ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Serialises a 64-bit {cmd, addr, data} frame onto a single line.
// Line format: start bit (0), then 64 payload bits with each field MSB first,
// followed by IDLE_GAP idle-high cycles before the next frame can be accepted.
// Ports:
//   clk      : sole clock, rising edge
//   rst      : asynchronous active-low reset
//   fif      : frame handshake (slave side), see serial_frame_tx_if
//   tx_out   : registered serial line, idles high
//   tx_busy  : high from acceptance until the idle gap ends
//   frm_done : one-cycle pulse once the last payload bit has been sent
//   frm_cnt  : count of completed frames, wraps silently
module serial_frame_tx #(
  parameter int IDLE_GAP = 2
) (
  input  logic               clk,
  input  logic               rst,
  serial_frame_tx_if.slave   fif,
  output logic               tx_out,
  output logic               tx_busy,
  output logic               frm_done,
  output logic [15:0]        frm_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SOP  = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_ADDR = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  // The gap counter counts down to zero, so it is loaded with one less than
  // the number of gap cycles.
  localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP - 1);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [6:0]  bit_q;    // payload bits currently put on the line, 0..64
  logic [63:0] sh_q;
  logic [3:0]  gap_q;
  logic        ready_q;
  logic [15:0] cnt_q;
  logic        accept;

  assign accept    = fif.valid && ready_q;
  assign fif.ready = ready_q;
  assign frm_cnt   = cnt_q;

  // bit_q always holds the index of the bit now on the line. A state therefore
  // advances on the edge that follows the last bit of its field.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SOP;
      S_SOP:   state_d = S_CMD;
      S_CMD:   if (bit_q == 7'd8)  state_d = S_ADDR;
      S_ADDR:  if (bit_q == 7'd32) state_d = S_DATA;
      S_DATA:  if (bit_q == 7'd64) state_d = S_GAP;
      S_GAP:   if (gap_q == 4'd0)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      bit_q    <= 7'd0;
      sh_q     <= 64'd0;
      gap_q    <= 4'd0;
      ready_q  <= 1'b0;
      cnt_q    <= 16'd0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      frm_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      // ready and busy are registered copies of the next state, so ready
      // drops in the cycle right after acceptance.
      ready_q  <= (state_d == S_IDLE);
      tx_busy  <= (state_d != S_IDLE);
      frm_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_out <= 1'b1;
          if (accept) begin
            sh_q   <= {fif.cmd, fif.addr, fif.data};
            tx_out <= 1'b0;
            bit_q  <= 7'd0;
          end
        end
        S_SOP, S_CMD, S_ADDR: begin
          tx_out <= sh_q[63];
          sh_q   <= {sh_q[62:0], 1'b0};
          bit_q  <= bit_q + 7'd1;
        end
        S_DATA: begin
          if (bit_q == 7'd64) begin
            tx_out   <= 1'b1;
            bit_q    <= 7'd0;
            frm_done <= 1'b1;
            cnt_q    <= cnt_q + 16'd1;
            gap_q    <= GAP_LOAD;
          end else begin
            tx_out <= sh_q[63];
            sh_q   <= {sh_q[62:0], 1'b0};
            bit_q  <= bit_q + 7'd1;
          end
        end
        S_GAP: begin
          tx_out <= 1'b1;
          if (gap_q != 4'd0) gap_q <= gap_q - 4'd1;
        end
        default: tx_out <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_out;
  logic        tx_busy;
  logic        frm_done;
  logic [15:0] frm_cnt;

  serial_frame_tx_if fif();

  serial_frame_tx #(.IDLE_GAP(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .fif      (fif.slave),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .frm_done (frm_done),
    .frm_cnt  (frm_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Length of the idle-high run that preceded the most recent falling edge.
  int   hi_run = 0;
  int   run_at_fall = -1;
  logic prev_tx = 1'b1;
  always @(negedge clk) begin
    if (tx_out === 1'b1) hi_run <= hi_run + 1;
    else begin
      if (prev_tx === 1'b1) run_at_fall <= hi_run;
      hi_run <= 0;
    end
    prev_tx <= tx_out;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int acc_cyc = 0;
  int last_gap = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Offers one frame and follows it on the line. Called at a negedge; returns
  // at the negedge after E66 (or right after an abort reset).
  task automatic send_frame(input string tag, input logic [7:0] c, input logic [23:0] a,
                            input logic [31:0] d, input bit hold, input bit abuse,
                            input int abort_at, input logic [15:0] cnt_exp);
    logic [63:0] got;
    int          lows;
    int          lows_exp;
    int          n;
    bit          done_bad;
    bit          busy_bad;
    logic        pre_tx;
    fif.valid = 1'b1;
    fif.cmd   = c;
    fif.addr  = a;
    fif.data  = d;
    n = 0;
    while (fif.ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (fif.ready !== 1'b1) begin
      chk({tag, ".ready_timeout"}, 64'(fif.ready), 64'd1);
      fif.valid = 1'b0;
      return;
    end
    pre_tx  = tx_out;
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    if (!hold) fif.valid = 1'b0;
    chk({tag, ".start"}, 64'(tx_out), 64'd0);
    chk({tag, ".ready_low"}, 64'(fif.ready), 64'd0);
    chk({tag, ".busy"}, 64'(tx_busy), 64'd1);
    #1 last_gap = run_at_fall;
    lows     = (tx_out === 1'b0) ? 1 : 0;
    got      = 64'd0;
    done_bad = 1'b0;
    busy_bad = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (abort_at == i) begin
        rst = 1'b0;
        #1;
        chk({tag, ".rst_tx"}, 64'(tx_out), 64'd1);
        chk({tag, ".rst_ready"}, 64'(fif.ready), 64'd0);
        chk({tag, ".rst_busy"}, 64'(tx_busy), 64'd0);
        chk({tag, ".rst_done"}, 64'(frm_done), 64'd0);
        chk({tag, ".rst_cnt"}, 64'(frm_cnt), 64'd0);
        fif.valid = 1'b0;
        return;
      end
      got = {got[62:0], tx_out};
      if (tx_out !== 1'b1) lows++;
      if (frm_done !== 1'b0) done_bad = 1'b1;
      if (tx_busy !== 1'b1 || fif.ready !== 1'b0) busy_bad = 1'b1;
      if (abuse) begin
        fif.valid = ~fif.valid;
        fif.cmd   = 8'($urandom);
        fif.addr  = 24'($urandom);
        fif.data  = $urandom;
      end
    end
    @(negedge clk);
    if (abuse) fif.valid = 1'b0;
    chk({tag, ".gap_tx"}, 64'(tx_out), 64'd1);
    chk({tag, ".done"}, 64'(frm_done), 64'd1);
    chk({tag, ".cnt"}, 64'(frm_cnt), 64'(cnt_exp));
    @(negedge clk);
    chk({tag, ".done_once"}, 64'(frm_done), 64'd0);
    chk({tag, ".busy_gap"}, 64'(tx_busy), 64'd1);
    chk({tag, ".cmd"}, 64'(got[63:56]), 64'(c));
    chk({tag, ".addr"}, 64'(got[55:32]), 64'(a));
    chk({tag, ".data"}, 64'(got[31:0]), 64'(d));
    chk({tag, ".pre_high"}, 64'(pre_tx), 64'd1);
    lows_exp = 1 + 64 - $countones({c, a, d});
    chk({tag, ".lows"}, 64'(lows), 64'(lows_exp));
    chk({tag, ".no_done_mid"}, 64'(done_bad), 64'd0);
    chk({tag, ".busy_mid"}, 64'(busy_bad), 64'd0);
  endtask

  int acc1;

  initial begin
    fif.valid = 1'b0;
    fif.cmd   = 8'd0;
    fif.addr  = 24'd0;
    fif.data  = 32'd0;
    #1 rst = 1'b0;
    #1;
    chk("reset.tx", 64'(tx_out), 64'd1);
    chk("reset.ready", 64'(fif.ready), 64'd0);
    chk("reset.busy", 64'(tx_busy), 64'd0);
    chk("reset.done", 64'(frm_done), 64'd0);
    chk("reset.cnt", 64'(frm_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("release.ready0", 64'(fif.ready), 64'd0);
    @(negedge clk);
    chk("release.ready1", 64'(fif.ready), 64'd1);

    send_frame("single", 8'hA5, 24'h123456, 32'hDEADBEEF, 1'b0, 1'b0, 0, 16'd1);

    send_frame("b2b1", 8'h11, 24'h223344, 32'h0F0F0F00, 1'b1, 1'b0, 0, 16'd2);
    acc1 = acc_cyc;
    send_frame("b2b2", 8'h3C, 24'hABCDEF, 32'h87654321, 1'b1, 1'b0, 0, 16'd3);
    fif.valid = 1'b0;
    chk("b2b.accept_gap", 64'(acc_cyc - acc1), 64'd68);
    chk("b2b.line_high", 64'(last_gap), 64'd3);

    send_frame("abuse", 8'h5A, 24'hC0FFEE, 32'h13579BDF, 1'b0, 1'b1, 0, 16'd4);
    repeat (4) @(negedge clk);
    chk("abuse.no_extra", 64'(tx_busy), 64'd0);
    chk("abuse.cnt", 64'(frm_cnt), 64'd4);

    send_frame("zeros", 8'h00, 24'h000000, 32'h00000000, 1'b0, 1'b0, 0, 16'd5);
    send_frame("ones", 8'hFF, 24'hFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 16'd6);

    send_frame("abort", 8'h00, 24'h000000, 32'h00000000, 1'b0, 1'b0, 20, 16'd0);
    repeat (3) @(negedge clk);
    chk("abort.hold_done", 64'(frm_done), 64'd0);
    chk("abort.hold_cnt", 64'(frm_cnt), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.ready_back", 64'(fif.ready), 64'd1);
    send_frame("recover", 8'hC3, 24'h0A0B0C, 32'h89ABCDEF, 1'b0, 1'b0, 0, 16'd1);

    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    #1 chk("wrap.preset", 64'(frm_cnt), 64'hFFFF);
    @(negedge clk);
    send_frame("wrap", 8'h96, 24'h654321, 32'h0BADF00D, 1'b0, 1'b0, 0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
